// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for serial_subtractor; master drives operands, slave returns the result.
interface serial_subtractor_if #(
  parameter int WIDTH = serial_subtractor_pkg::DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (output start, a, b, input busy, done, diff, bout);
  modport slave  (input start, a, b, output busy, done, diff, bout);
endinterface

// File: rtl/serial_subtractor_full_subtractor_1.sv
// One-bit full subtractor: d = a - b - bi, bo = borrow out. Purely combinational.
module full_subtractor_1 (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first a - b; result WIDTH+1 cycles after accept, start ignored while busy.
// SERSUB_SAT_EN: clamp diff to zero when the final borrow is set.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int               CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] diff_final;
  logic             borrow;
  logic [CNT_W-1:0] cnt;
  logic             d_bit;
  logic             br_next;

  full_subtractor_1 u_cell (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .bi (borrow),
    .d  (d_bit),
    .bo (br_next)
  );

  // The result fills from the top so after WIDTH shifts bit 0 holds the first difference bit.
  always_comb begin
    res_next            = res_sr >> 1;
    res_next[WIDTH-1]   = d_bit;
`ifdef SERSUB_SAT_EN
    diff_final = br_next ? '0 : res_next;
`else
    diff_final = res_next;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      borrow   <= 1'b0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.diff <= '0;
      bus.bout <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_sr     <= bus.a;
            b_sr     <= bus.b;
            res_sr   <= '0;
            borrow   <= 1'b0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end else begin
            state    <= IDLE;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          borrow <= br_next;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.diff <= diff_final;
            bus.bout <= br_next;
            state    <= DONE;
          end
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: table vectors, hand-written corner sequences, random pairs, scoreboard on done.
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  localparam int W = 8;
`ifdef SERSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus8 ();
  serial_subtractor_if #(.WIDTH(1)) bus1 ();

  serial_subtractor #(.WIDTH(W)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_diff;
    logic       exp_bout;
    int         acc_cyc;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_diff;
    logic       exp_bout;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest accepted operation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus8.done) begin
      check("done_single_cycle", {31'd0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("diff", {24'd0, bus8.diff}, {24'd0, e.exp_diff});
        check("bout", {31'd0, bus8.bout}, {31'd0, e.exp_bout});
        check("latency", cyc - e.acc_cyc, W);
      end
    end
    prev_done = bus8.done;
  end

  function automatic vec_t model(logic [7:0] a, logic [7:0] b);
    vec_t v;
    v.a        = a;
    v.b        = b;
    v.exp_diff = a - b;
    v.exp_bout = (a < b);
    if (SAT && v.exp_bout) v.exp_diff = 8'd0;
    return v;
  endfunction

  task automatic push_exp(vec_t v);
    exp_t e;
    e.a        = v.a;
    e.b        = v.b;
    e.exp_diff = v.exp_diff;
    e.exp_bout = v.exp_bout;
    e.acc_cyc  = cyc;
    sb.push_back(e);
  endtask

  // Drives a one-cycle start; returns at the negedge after the accepting edge.
  task automatic issue(vec_t v);
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = v.a;
    bus8.b     = v.b;
    @(posedge clk);
    #1 push_exp(v);
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    vec_t v;
    int   n;
    logic [1:0] p;

    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0;

    // Table: hand-derived results
    vecs.push_back('{8'd200, 8'd55,  8'd145,               1'b0});
    vecs.push_back('{8'd55,  8'd200, SAT ? 8'd0 : 8'd111,  1'b1});
    vecs.push_back('{8'hAA,  8'hAA,  8'h00,                1'b0});
    vecs.push_back('{8'h00,  8'h01,  SAT ? 8'h00 : 8'hFF,  1'b1});
    vecs.push_back('{8'hFF,  8'h00,  8'hFF,                1'b0});
    vecs.push_back('{8'h00,  8'h00,  8'h00,                1'b0});
    vecs.push_back('{8'h01,  8'hFF,  SAT ? 8'h00 : 8'h02,  1'b1});
    vecs.push_back('{8'h80,  8'h7F,  8'h01,                1'b0});

    #12;
    check("rst_busy8", {31'd0, bus8.busy}, 0);
    check("rst_done8", {31'd0, bus8.done}, 0);
    check("rst_diff8", {24'd0, bus8.diff}, 0);
    check("rst_bout8", {31'd0, bus8.bout}, 0);
    check("rst_busy1", {31'd0, bus1.busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i]);
      n = 0;
      repeat (W + 3) begin
        if (bus8.busy) n++;
        @(negedge clk);
      end
      check("busy_cycles", n, W);
      wait_idle(40);
    end

    // start pulsed with junk operands throughout RUN is ignored
    issue('{8'h30, 8'h10, 8'h20, 1'b0});
    repeat (W - 2) begin
      bus8.start = 1'b1;
      bus8.a     = 8'($urandom);
      bus8.b     = 8'($urandom);
      @(negedge clk);
    end
    bus8.start = 1'b0;
    wait_idle(40);

    // start held across DONE: second operation begins with no IDLE cycle
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a = 8'd100;
    bus8.b = 8'd30;
    @(posedge clk);
    #1 push_exp('{8'd100, 8'd30, 8'd70, 1'b0});
    @(negedge clk);
    bus8.a = 8'd7;
    bus8.b = 8'd9;
    n = 0;
    while (!bus8.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus8.done) check("b2b_done_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1 push_exp('{8'd7, 8'd9, SAT ? 8'h00 : 8'hFE, 1'b1});
    check("b2b_busy", {31'd0, bus8.busy}, 1);
    @(negedge clk);
    bus8.start = 1'b0;
    wait_idle(40);

    // Reset in RUN cycle 4: outputs clear at once and done never pulses
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a = 8'd50;
    bus8.b = 8'd20;
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, bus8.busy}, 0);
    check("midrst_done", {31'd0, bus8.done}, 0);
    check("midrst_diff", {24'd0, bus8.diff}, 0);
    check("midrst_bout", {31'd0, bus8.bout}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 2) @(negedge clk);
    issue('{8'd50, 8'd20, 8'd30, 1'b0});
    wait_idle(40);

    for (int i = 0; i < 1000; i++) begin
      v = model(8'($urandom), 8'($urandom));
      issue(v);
      wait_idle(40);
    end

    // WIDTH = 1: RUN lasts one cycle, done in the cycle after the next edge
    for (int i = 0; i < 4; i++) begin
      p = 2'(i);
      @(negedge clk);
      bus1.start = 1'b1;
      bus1.a     = p[1];
      bus1.b     = p[0];
      @(negedge clk);
      bus1.start = 1'b0;
      check("w1_busy", {31'd0, bus1.busy}, 1);
      check("w1_done_early", {31'd0, bus1.done}, 0);
      @(negedge clk);
      check("w1_done", {31'd0, bus1.done}, 1);
      check("w1_diff", {31'd0, bus1.diff},
            {31'd0, (SAT && !p[1] && p[0]) ? 1'b0 : (p[1] ^ p[0])});
      check("w1_bout", {31'd0, bus1.bout}, {31'd0, ~p[1] & p[0]});
      @(negedge clk);
      check("w1_done_clear", {31'd0, bus1.done}, 0);
    end

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor, LSB-first; computes diff = a - b over WIDTH clock cycles, one bit per cycle.
- It is the inverse arithmetic direction of the team's full-adder cell: it uses a full-subtractor (borrow-chain) cell, with the borrow registered between cycles.
- It sits beside the adder datapath as a small-area alternative for wide operands where one result every WIDTH+1 cycles is acceptable.

Parameters:
- WIDTH, 8, operand and result width in bits; must be >= 1.

Ports:
- clk    input   1      rising-edge clock
- rst_n  input   1      asynchronous active-low reset
- start  input   1      request; sampled only in IDLE or DONE
- a      input   WIDTH  minuend; captured on the accepting edge
- b      input   WIDTH  subtrahend; captured on the accepting edge
- busy   output  1      high while in RUN
- done   output  1      one-cycle pulse; diff and bout are valid
- diff   output  WIDTH  difference; holds until the next accepted start
- bout   output  1      final borrow (1 = a < b); holds with diff

Interface: one clock, clk; reset rst_n is asynchronous and active-low.

Behaviour:
- Reset: asserting rst_n low forces the following immediately, independent of clk:
  - state = IDLE
  - busy = 0, done = 0, diff = 0, bout = 0
  - internal shift registers, borrow register and counter = 0
  - Reset in the middle of a RUN abandons the operation; done does not pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start = 1 on an edge: latch a and b into shift registers, set borrow = 0 and cnt = 0, go to RUN.
  - Otherwise stay in IDLE.
- RUN (busy = 1), on every edge:
  - Take a0 = LSB of the a shift register, b0 = LSB of the b shift register, br = borrow register.
  - d = a0 ^ b0 ^ br.
  - br' = (~a0 & b0) | (~(a0 ^ b0) & br).
  - Shift both operand registers right by one.
  - Shift d into the MSB of the result shift register.
  - Store br' in the borrow register; cnt = cnt + 1.
  - When cnt reaches WIDTH-1 on an edge, that edge performs the last bit and goes to DONE.
  - start is ignored throughout RUN.
- DONE (lasts one cycle):
  - done = 1, busy = 0.
  - diff = result register; bout = final borrow.
  - If start = 1 on this edge: accept the new operands and go to RUN directly (back-to-back operation); diff and bout then hold until the next DONE.
  - Otherwise go to IDLE.
- Latency: if start is accepted on edge k, done is high in the cycle following edge k+WIDTH. Throughput is one result per WIDTH+1 cycles.
- Arithmetic: modulo 2^WIDTH; bout = 1 exactly when a < b (unsigned).
- Counter width: $clog2(WIDTH+1). WIDTH = 1 is legal: RUN lasts exactly one cycle.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: SERSUB_SAT_EN.
- Defined: on DONE, if the final borrow = 1, diff is forced to 0 (unsigned saturation at zero); bout still reports 1.
- Undefined: diff is the wrapped two's-complement result.
- Timing and handshake are identical in both builds.

Decomposition:
- Package serial_subtractor_pkg holds:
  - state enum type (IDLE, RUN, DONE)
  - default WIDTH constant
- Sub-module full_subtractor_1 is the one natural split: combinational, ports a, b, bi, d, bo, implementing the d/br' equations above. It is instantiated once as the serial cell.

Test Plan:
- WIDTH=8, a=200, b=55, start for 1 cycle -> busy high for 8 cycles; done pulses 9 cycles after the accepting edge; diff=145, bout=0.
- a=55, b=200 -> diff=111, bout=1; with SERSUB_SAT_EN defined -> diff=0, bout=1.
- a=0xAA, b=0xAA -> diff=0, bout=0. a=0, b=1 -> diff=0xFF, bout=1 (0 with SAT).
- start pulsed repeatedly with new operands during RUN -> ignored; result matches the first operands. start held high across DONE -> second operation begins with no IDLE cycle; second result correct.
- rst_n low at RUN cycle 4 -> all outputs 0 immediately, no done pulse; a fresh start afterwards completes correctly.
- WIDTH=1: a=0, b=1 -> done after 2 cycles, diff=1, bout=1. Randomized 1000 pairs against a behavioural model -> all match.
